operand_fetch: RTL and testbench

Register-read stage that sits between decode and execute and is the initiator on the register file read port.
- Drives source selects to the register file and absorbs its 1-cycle registered read latency.
- Bypasses writeback data, because the register file has no write-through on the write edge.
- Tracks in-flight destinations with a 32-bit pending scoreboard and issues operands downstream over a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/operand_fetch_scoreboard.sv | 39 +++
 rtl/operand_fetch.sv | 121 ++++++++++++
 tb/tb_operand_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-index types and the decoded operand request used by the fetch stage.
package riscv_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     use_rs1;
    logic     use_rs2;
    logic     wr_rd;
  } fetch_req_t;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue, cleared on writeback.
module operand_fetch_scoreboard
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  input  reg_idx_t rd_idx,
  output logic     rs1_pend,
  output logic     rs2_pend,
  output logic     rd_pend
);

  logic [NUM_REGS-1:0] pending_p0;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  assign set_vec = set_en ? idx_onehot(set_idx) : '0;
  assign clr_vec = clr_en ? idx_onehot(clr_idx) : '0;

  // A set and a clear to the same index in one cycle leave the bit set; x0 never pends.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p0 <= '0;
    end else begin
      pending_p0 <= ((pending_p0 & ~clr_vec) | set_vec) & ~idx_onehot('0);
    end
  end

  assign rs1_pend = pending_p0[rs1_idx];
  assign rs2_pend = pending_p0[rs2_idx];
  assign rd_pend  = pending_p0[rd_idx];

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: single hold slot that reads the register file, bypasses writeback
// and stalls on the pending scoreboard before handing operands to execute.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4:0]           in_rs1_i,
  input  logic [4:0]           in_rs2_i,
  input  logic [4:0]           in_rd_i,
  input  logic                 in_use_rs1_i,
  input  logic                 in_use_rs2_i,
  input  logic                 in_wr_rd_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic [4:0]           rf_sel_rs1_o,
  output logic [4:0]           rf_sel_rs2_o,
  input  logic [DATA_W-1:0]    rf_rs1_i,
  input  logic [DATA_W-1:0]    rf_rs2_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_sel_rd_i,
  input  logic [DATA_W-1:0]    wb_rd_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_W-1:0]    out_rs1_o,
  output logic [DATA_W-1:0]    out_rs2_o,
  output logic [4:0]           out_rd_o,
  output logic                 out_wr_rd_o,
  output logic [PAYLOAD_W-1:0] out_payload_o
);

  fetch_req_t            in_req;
  fetch_req_t            h_req_p0;
  logic [PAYLOAD_W-1:0]  h_payload_p0;
  logic                  held_p0;
  logic                  byp1_v_p0, byp2_v_p0;
  logic [DATA_W-1:0]     byp1_d_p0, byp2_d_p0;

  logic                  fire, accept;
  logic                  hit1, hit2;
  logic                  rs1_pend, rs2_pend, rd_pend;
  logic                  rs1_ok, rs2_ok, waw_ok;

  assign in_req = '{rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i,
                    use_rs1: in_use_rs1_i, use_rs2: in_use_rs2_i, wr_rd: in_wr_rd_i};

  assign fire       = out_valid_o & out_ready_i;
  assign in_ready_o = !flush_i & (!held_p0 | fire);
  assign accept     = in_valid_i & in_ready_o;

  // The register file read is registered, so the select always points at whatever H holds next cycle.
  assign rf_sel_rs1_o = accept ? in_rs1_i : h_req_p0.rs1;
  assign rf_sel_rs2_o = accept ? in_rs2_i : h_req_p0.rs2;

  assign hit1 = wb_we_i & (wb_sel_rd_i == rf_sel_rs1_o) & (rf_sel_rs1_o != '0);
  assign hit2 = wb_we_i & (wb_sel_rd_i == rf_sel_rs2_o) & (rf_sel_rs2_o != '0);

  // Stage H: hold slot plus sticky per-source writeback capture
  always_ff @(posedge clk) begin
    if (rst) begin
      held_p0      <= 1'b0;
      h_req_p0     <= '0;
      h_payload_p0 <= '0;
      byp1_v_p0    <= 1'b0;
      byp2_v_p0    <= 1'b0;
      byp1_d_p0    <= '0;
      byp2_d_p0    <= '0;
    end else if (accept) begin
      held_p0      <= 1'b1;
      h_req_p0     <= in_req;
      h_payload_p0 <= in_payload_i;
      byp1_v_p0    <= hit1;
      byp2_v_p0    <= hit2;
      if (hit1) byp1_d_p0 <= wb_rd_i;
      if (hit2) byp2_d_p0 <= wb_rd_i;
    end else if (flush_i || fire) begin
      held_p0 <= 1'b0;
    end else if (held_p0) begin
      if (hit1) begin
        byp1_v_p0 <= 1'b1;
        byp1_d_p0 <= wb_rd_i;
      end
      if (hit2) begin
        byp2_v_p0 <= 1'b1;
        byp2_d_p0 <= wb_rd_i;
      end
    end
  end

  operand_fetch_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (fire & h_req_p0.wr_rd & (h_req_p0.rd != '0)),
    .set_idx  (h_req_p0.rd),
    .clr_en   (wb_we_i),
    .clr_idx  (wb_sel_rd_i),
    .rs1_idx  (h_req_p0.rs1),
    .rs2_idx  (h_req_p0.rs2),
    .rd_idx   (h_req_p0.rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

  assign rs1_ok = !h_req_p0.use_rs1 | (h_req_p0.rs1 == '0) | !rs1_pend | byp1_v_p0;
  assign rs2_ok = !h_req_p0.use_rs2 | (h_req_p0.rs2 == '0) | !rs2_pend | byp2_v_p0;
  assign waw_ok = !(h_req_p0.wr_rd & (h_req_p0.rd != '0) & rd_pend);

  assign out_valid_o   = held_p0 & rs1_ok & rs2_ok & waw_ok;
  assign out_rs1_o     = (h_req_p0.rs1 == '0) ? '0 : (byp1_v_p0 ? byp1_d_p0 : rf_rs1_i);
  assign out_rs2_o     = (h_req_p0.rs2 == '0) ? '0 : (byp2_v_p0 ? byp2_d_p0 : rf_rs2_i);
  assign out_rd_o      = h_req_p0.rd;
  assign out_wr_rd_o   = h_req_p0.wr_rd;
  assign out_payload_o = h_payload_p0;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read register file model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_wr_rd;
  logic [63:0] in_payload;
  logic [4:0]  rf_sel_rs1, rf_sel_rs2;
  logic [31:0] rf_rs1, rf_rs2;
  logic        wb_we;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1, out_rs2;
  logic [4:0]  out_rd;
  logic        out_wr_rd;
  logic [63:0] out_payload;

  logic [31:0] rf_mem [32];
  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Register file: registered read, no write-through on the write edge.
  always @(posedge clk) begin
    rf_rs1 <= rf_mem[rf_sel_rs1];
    rf_rs2 <= rf_mem[rf_sel_rs2];
    if (wb_we) rf_mem[wb_sel] <= wb_data;
  end

  operand_fetch #(.DATA_W(32), .PAYLOAD_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
    .in_use_rs1_i(in_use_rs1), .in_use_rs2_i(in_use_rs2), .in_wr_rd_i(in_wr_rd),
    .in_payload_i(in_payload),
    .rf_sel_rs1_o(rf_sel_rs1), .rf_sel_rs2_o(rf_sel_rs2),
    .rf_rs1_i(rf_rs1), .rf_rs2_i(rf_rs2),
    .wb_we_i(wb_we), .wb_sel_rd_i(wb_sel), .wb_rd_i(wb_data),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
    .out_wr_rd_o(out_wr_rd), .out_payload_o(out_payload)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic wr, input logic [63:0] pl);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = wr; in_payload = pl;
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] sel, input logic [31:0] d);
    wb_we = we; wb_sel = sel; wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[0] = 32'h5A5A;
    rf_mem[5] = 32'h11;
    rf_mem[6] = 32'h22;
    rf_mem[7] = 32'h777;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_rs1", 64'(out_rs1), 64'd0);
    chk("rst_out_rs2", 64'(out_rs2), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wr_rd", 64'(out_wr_rd), 64'd0);
    chk("rst_out_payload", out_payload, 64'd0);
    chk("rst_pending", 64'(dut.u_sb.pending_p0), 64'd0);

    // Basic issue: x5, x6 from the register file, one cycle after accept
    drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 64'hABCD);
    chk("a_sel_rs1", 64'(rf_sel_rs1), 64'd5);
    chk("a_sel_rs2", 64'(rf_sel_rs2), 64'd6);
    chk("a_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("a_out_valid", 64'(out_valid), 64'd1);
    chk("a_out_rs1", 64'(out_rs1), 64'h11);
    chk("a_out_rs2", 64'(out_rs2), 64'h22);
    chk("a_out_rd", 64'(out_rd), 64'd8);
    chk("a_out_wr_rd", 64'(out_wr_rd), 64'd1);
    chk("a_out_payload", out_payload, 64'hABCD);
    tick();
    chk("a_after_fire_valid", 64'(out_valid), 64'd0);
    chk("a_pending8", 64'(dut.u_sb.pending_p0), 64'h100);
    wb(1'b1, 5'd8, 32'h88);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("a_pending_clr", 64'(dut.u_sb.pending_p0), 64'd0);

    // Dependent back-to-back through a writeback bypass
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 64'h700);
    tick();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 64'h701);
    chk("b_prod_valid", 64'(out_valid), 64'd1);
    chk("b_in_ready_fire", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("b_stall0", 64'(out_valid), 64'd0);
    chk("b_pending7", 64'(dut.u_sb.pending_p0), 64'h80);
    tick();
    chk("b_stall1", 64'(out_valid), 64'd0);
    wb(1'b1, 5'd7, 32'hDEAD);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("b_wb_valid", 64'(out_valid), 64'd1);
    chk("b_wb_rs1", 64'(out_rs1), 64'hDEAD);
    chk("b_rf_old", 64'(rf_rs1), 64'h777);
    chk("b_payload", out_payload, 64'h701);
    tick();
    chk("b_fired", 64'(out_valid), 64'd0);

    // Backpressure: five stalled cycles, then one fire with same-cycle accept
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 5'd6, 5'd11, 1'b1, 1'b1, 1'b1, 64'hC1);
    tick();
    drive(1'b1, 5'd6, 5'd5, 5'd12, 1'b1, 1'b1, 1'b1, 64'hC2);
    for (int i = 0; i < 5; i++) begin
      chk("c_hold_valid", 64'(out_valid), 64'd1);
      chk("c_hold_in_ready", 64'(in_ready), 64'd0);
      chk("c_hold_rs1", 64'(out_rs1), 64'h11);
      chk("c_hold_payload", out_payload, 64'hC1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("c_ready_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("c_next_valid", 64'(out_valid), 64'd1);
    chk("c_next_payload", out_payload, 64'hC2);
    chk("c_next_rs1", 64'(out_rs1), 64'h22);
    chk("c_one_fire_pending", 64'(dut.u_sb.pending_p0), 64'h800);
    tick();
    chk("c_both_pending", 64'(dut.u_sb.pending_p0), 64'h1800);
    wb(1'b1, 5'd11, 32'hB11);
    tick();
    wb(1'b1, 5'd12, 32'hB12);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("c_pending_clr", 64'(dut.u_sb.pending_p0), 64'd0);

    // x0 source and destination
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 64'hD0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("d_x0_valid", 64'(out_valid), 64'd1);
    chk("d_x0_rs1", 64'(out_rs1), 64'd0);
    tick();
    chk("d_x0_pending", 64'(dut.u_sb.pending_p0), 64'd0);

    // Flush of an instruction stalled on x9
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 64'hE0);
    tick();
    drive(1'b1, 5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 64'hE1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("e_stall", 64'(out_valid), 64'd0);
    chk("e_pending9", 64'(dut.u_sb.pending_p0), 64'h200);
    flush = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 64'hE2);
    chk("e_flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("e_empty_valid", 64'(out_valid), 64'd0);
    chk("e_empty_in_ready", 64'(in_ready), 64'd1);
    chk("e_pending_kept", 64'(dut.u_sb.pending_p0), 64'h200);
    wb(1'b1, 5'd9, 32'h99);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("e_no_ghost_valid", 64'(out_valid), 64'd0);
    chk("e_pending_clr", 64'(dut.u_sb.pending_p0), 64'd0);

    // Set and clear of x9 on the same edge: set wins
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 64'hF0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    wb(1'b1, 5'd9, 32'h199);
    chk("f_prod_valid", 64'(out_valid), 64'd1);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("f_set_wins", 64'(dut.u_sb.pending_p0), 64'h200);
    wb(1'b1, 5'd9, 32'h299);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("f_pending_clr", 64'(dut.u_sb.pending_p0), 64'd0);

    // Reset mid-operation drops the held instruction
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 5'd6, 5'd14, 1'b1, 1'b1, 1'b1, 64'h77);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("g_held_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("g_rst_valid", 64'(out_valid), 64'd0);
    chk("g_rst_in_ready", 64'(in_ready), 64'd1);
    chk("g_rst_payload", out_payload, 64'd0);
    chk("g_rst_rd", 64'(out_rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
